// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO; in clock/reset/wn/rn/data_in, out data_out/full/empty/almost_full/almost_empty/count/overflow/underflow
module sync_fifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wn,
  input  logic                     rn,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_TH);
  assign almost_empty = count <= CW'(AE_TH);
  // a read in the same edge frees a slot, so a full FIFO still takes the write
  assign wr_en = wn & (~full | rn);
  assign rd_en = rn & ~empty;
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= data_in;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
      count <= (wr_en & ~rd_en) ? count + 1'b1 : (rd_en & ~wr_en) ? count - 1'b1 : count;
      data_out <= rd_en ? mem[rd_ptr] : data_out;
      overflow <= wn & full & ~rn;
      underflow <= rn & empty;
    end
endmodule
